// File: rtl/hwag_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hwag_cfg_pkg
// Brief    : Shared types and constants for the HWAG configuration loader.
// Revision : 1.0 - initial release
// ============================================================================
package hwag_cfg_pkg;

    // Default ssram geometry
    localparam int HWAG_ADDR_W = 8;
    localparam int HWAG_DATA_W = 16;

    // Named hwag register addresses
    localparam int HWATHNB = 4;
    localparam int HWASTWD = 5;
    localparam int HWAATOP = 6;
    localparam int HWACR0  = 64;
    localparam int HWATHVL = 70;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_TURN  = 3'd2,
        ST_READ  = 3'd3,
        ST_TAIL  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hwag_cfg_rom.sv
`default_nettype none
// ============================================================================
// Module   : hwag_cfg_rom
// Brief    : Init table for the HWAG loader: value and verify flag per index.
// Revision : 1.0 - initial release
// ============================================================================
module hwag_cfg_rom
    import hwag_cfg_pkg::*;
#(
    parameter int ADDR_W = HWAG_ADDR_W,
    parameter int DATA_W = HWAG_DATA_W
) (
    input  logic [ADDR_W-1:0] tbl_addr,
    output logic [DATA_W-1:0] tbl_data,
    output logic              tbl_vfy
);

    // Table entry k holds k*3; every entry is checked on readback
    assign tbl_data = DATA_W'(tbl_addr) * DATA_W'(3);
    assign tbl_vfy  = 1'b1;

endmodule
`default_nettype wire

// File: rtl/hwag_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : hwag_cfg_seq
// Brief    : Loads N_REGS hwag registers from the init table over the ssram
//            port, then reads them back and verifies flagged entries.
// Revision : 1.0 - initial release
// ============================================================================
module hwag_cfg_seq
    import hwag_cfg_pkg::*;
#(
    parameter int N_REGS = 71,
    parameter int ADDR_W = HWAG_ADDR_W,
    parameter int DATA_W = HWAG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic              tbl_vfy,
    output logic              ssram_we,
    output logic              ssram_re,
    output logic [ADDR_W-1:0] ssram_addr,
    output logic [DATA_W-1:0] ssram_wdata,
    output logic              ssram_oe,
    input  logic [DATA_W-1:0] ssram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    // One extra counter bit so N_REGS = 2**ADDR_W reaches its last index cleanly
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N_REGS - 1);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    state_t            state_q;
    logic [ADDR_W:0]   cnt_q;
    logic              we_q;
    logic              re_q;
    logic              oe_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic [DATA_W-1:0] exp_q;
    logic              vfy_q;
    logic              cmp_vld_q;
    logic [ADDR_W-1:0] cmp_addr_q;

    logic cnt_last;
    logic mismatch;

    // Readback of the previous cycle's read is compared against the value
    // captured when that read was issued
    assign cnt_last = (cnt_q == LAST);
    assign mismatch = cmp_vld_q && vfy_q && (ssram_rdata != exp_q);

    // Sequencer: write pass, one turnaround cycle, read/verify pass
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            exp_q      <= '0;
            vfy_q      <= 1'b0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
        end else begin
            cmp_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_q    <= ST_WRITE;
                        cnt_q      <= '0;
                        we_q       <= 1'b1;
                        oe_q       <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_addr_q <= '0;
                    end
                end
                ST_WRITE: begin
                    if (cnt_last) begin
                        state_q <= ST_TURN;
                        we_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                ST_TURN: begin
                    state_q <= ST_READ;
                    re_q    <= 1'b1;
                end
                ST_READ: begin
                    exp_q      <= tbl_data;
                    vfy_q      <= tbl_vfy;
                    cmp_addr_q <= cnt_q[ADDR_W-1:0];
                    cmp_vld_q  <= 1'b1;
                    if (mismatch) begin
                        state_q    <= ST_ERR;
                        re_q       <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        err_addr_q <= cmp_addr_q;
                        cmp_vld_q  <= 1'b0;
                    end else if (cnt_last) begin
                        state_q <= ST_TAIL;
                        re_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                ST_TAIL: begin
                    busy_q <= 1'b0;
                    if (mismatch) begin
                        state_q    <= ST_ERR;
                        err_q      <= 1'b1;
                        err_addr_q <= cmp_addr_q;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    we_q    <= 1'b0;
                    re_q    <= 1'b0;
                    oe_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tbl_addr    = cnt_q[ADDR_W-1:0];
    assign ssram_addr  = cnt_q[ADDR_W-1:0];
    assign ssram_wdata = we_q ? tbl_data : '0;
    assign ssram_we    = we_q;
    assign ssram_re    = re_q;
    assign ssram_oe    = oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_hwag_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwag_cfg_seq
// Brief    : Self-checking bench for hwag_cfg_seq with an echoing ssram model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwag_cfg_seq;

    localparam int N  = 71;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    logic start71;
    logic start1;

    always #5 clk = ~clk;

    // ---------------- DUT with N_REGS = 71 ----------------
    logic [AW-1:0] a_tbl_addr, a_addr, a_err_addr;
    logic [DW-1:0] a_tbl_data, a_wdata, a_rdata;
    logic          a_rom_vfy, a_tbl_vfy, a_we, a_re, a_oe, a_busy, a_done, a_err;

    bit hole_en;
    int hole_addr;
    bit corrupt_en;
    int corrupt_addr;

    hwag_cfg_rom #(.ADDR_W(AW), .DATA_W(DW)) u_rom_a (
        .tbl_addr(a_tbl_addr), .tbl_data(a_tbl_data), .tbl_vfy(a_rom_vfy));

    assign a_tbl_vfy = a_rom_vfy & ~(hole_en & (int'(a_tbl_addr) == hole_addr));

    hwag_cfg_seq #(.N_REGS(N), .ADDR_W(AW), .DATA_W(DW)) u_dut_a (
        .clk(clk), .rst(rst), .start(start71),
        .tbl_addr(a_tbl_addr), .tbl_data(a_tbl_data), .tbl_vfy(a_tbl_vfy),
        .ssram_we(a_we), .ssram_re(a_re), .ssram_addr(a_addr),
        .ssram_wdata(a_wdata), .ssram_oe(a_oe), .ssram_rdata(a_rdata),
        .busy(a_busy), .done(a_done), .err(a_err), .err_addr(a_err_addr));

    logic [DW-1:0] mem_a [0:255];
    always @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= a_wdata;
        if (a_re) a_rdata <= (corrupt_en && int'(a_addr) == corrupt_addr) ? 16'hFFFF : mem_a[a_addr];
    end

    // ---------------- DUT with N_REGS = 1 ----------------
    logic [AW-1:0] b_tbl_addr, b_addr, b_err_addr;
    logic [DW-1:0] b_tbl_data, b_wdata, b_rdata;
    logic          b_tbl_vfy, b_we, b_re, b_oe, b_busy, b_done, b_err;

    hwag_cfg_rom #(.ADDR_W(AW), .DATA_W(DW)) u_rom_b (
        .tbl_addr(b_tbl_addr), .tbl_data(b_tbl_data), .tbl_vfy(b_tbl_vfy));

    hwag_cfg_seq #(.N_REGS(1), .ADDR_W(AW), .DATA_W(DW)) u_dut_b (
        .clk(clk), .rst(rst), .start(start1),
        .tbl_addr(b_tbl_addr), .tbl_data(b_tbl_data), .tbl_vfy(b_tbl_vfy),
        .ssram_we(b_we), .ssram_re(b_re), .ssram_addr(b_addr),
        .ssram_wdata(b_wdata), .ssram_oe(b_oe), .ssram_rdata(b_rdata),
        .busy(b_busy), .done(b_done), .err(b_err), .err_addr(b_err_addr));

    logic [DW-1:0] mem_b [0:255];
    always @(posedge clk) begin
        if (b_we) mem_b[b_addr] <= b_wdata;
        if (b_re) b_rdata <= mem_b[b_addr];
    end

    // ---------------- checking ----------------
    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Bus protocol and write/read ordering on the 71-register DUT
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk1("we_re_exclusive", a_we & a_re, 1'b0);
            chk1("oe_only_in_write", a_oe, a_we);
            if (a_we === 1'b1) begin
                chkw("wr_addr", 32'(a_addr), 32'(wr_cnt));
                chkw("wr_tbl_addr", 32'(a_tbl_addr), 32'(wr_cnt));
                chkw("wr_data", 32'(a_wdata), 32'(wr_cnt * 3));
                wr_cnt++;
            end
            if (a_re === 1'b1) begin
                chkw("rd_addr", 32'(a_addr), 32'(rd_cnt));
                rd_cnt++;
            end
        end
    end

    // One full sequence on the 71-register DUT; corr<0 means clean readback,
    // hole clears vfy at the corrupted address, mid pulses start while busy
    task automatic run71(input int corr, input bit hole, input bit mid);
        int c, term, s, exp_rd;
        corrupt_en   = (corr >= 0);
        corrupt_addr = corr;
        hole_en      = hole;
        hole_addr    = corr;
        c      = (corr >= 0 && !hole) ? corr : -1;
        term   = (c >= 0) ? N + c + 4 : 2 * N + 3;
        s      = mid ? N + 2 + int'($urandom_range(0, term - 1 - (N + 2))) : -1;
        exp_rd = (c < 0) ? N : ((c + 2 > N) ? N : c + 2);
        @(negedge clk);
        wr_cnt  = 0;
        rd_cnt  = 0;
        start71 = 1'b1;
        for (int cyc = 1; cyc <= 2 * N + 4; cyc++) begin
            @(negedge clk);
            start71 = (cyc == s);
            chk1("busy", a_busy, cyc < term);
            chk1("done", a_done, (c < 0) && (cyc >= term));
            chk1("err", a_err, (c >= 0) && (cyc >= term));
        end
        chkw("err_addr", 32'(a_err_addr), (c >= 0) ? 32'(c) : 32'd0);
        chkw("write_count", 32'(wr_cnt), 32'(N));
        chkw("read_count", 32'(rd_cnt), 32'(exp_rd));
        chk1("re_idle", a_re, 1'b0);
        corrupt_en = 1'b0;
        hole_en    = 1'b0;
    endtask

    initial begin
        start71    = 1'b0;
        start1     = 1'b0;
        hole_en    = 1'b0;
        corrupt_en = 1'b0;
        rst        = 1'b1;
        #1 rst     = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk1("rst_we", a_we, 1'b0);
        chk1("rst_re", a_re, 1'b0);
        chk1("rst_oe", a_oe, 1'b0);
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_done", a_done, 1'b0);
        chk1("rst_err", a_err, 1'b0);
        chkw("rst_err_addr", 32'(a_err_addr), 32'd0);
        chkw("rst_ssram_addr", 32'(a_addr), 32'd0);
        chkw("rst_wdata", 32'(a_wdata), 32'd0);
        chkw("rst_tbl_addr", 32'(a_tbl_addr), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk1("idle_no_start", a_busy, 1'b0);

        // clean load, mid-sequence start ignored, restart from DONE
        run71(-1, 1'b0, 1'b0);
        run71(-1, 1'b0, 1'b1);
        run71(-1, 1'b0, 1'b0);

        // verify failures and the masked-address case
        run71(57, 1'b0, 1'b0);
        run71(64, 1'b1, 1'b0);
        run71(0, 1'b0, 1'b0);
        run71(N - 1, 1'b0, 1'b0);

        // asynchronous reset during the write of address 20
        @(negedge clk);
        wr_cnt  = 0;
        rd_cnt  = 0;
        start71 = 1'b1;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            @(negedge clk);
            start71 = 1'b0;
        end
        chkw("pre_rst_addr", 32'(a_addr), 32'd20);
        #2 rst = 1'b0;
        #1;
        chk1("async_rst_we", a_we, 1'b0);
        chk1("async_rst_re", a_re, 1'b0);
        chk1("async_rst_oe", a_oe, 1'b0);
        chk1("async_rst_busy", a_busy, 1'b0);
        chkw("async_rst_addr", 32'(a_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk1("post_rst_idle", a_busy, 1'b0);
        chk1("post_rst_done", a_done, 1'b0);
        chkw("post_rst_writes", 32'(wr_cnt), 32'd21);
        run71(-1, 1'b0, 1'b0);

        // randomized corruption / mask / mid-start mixes
        for (int t = 0; t < 8; t++) begin
            int corr;
            corr = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, N - 1));
            run71(corr, 1'(corr >= 0 && $urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end

        // single-register sequence
        @(negedge clk);
        start1 = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk1("n1_we", b_we, cyc == 1);
            chk1("n1_oe", b_oe, cyc == 1);
            chk1("n1_re", b_re, cyc == 3);
            chk1("n1_busy", b_busy, cyc <= 4);
            chk1("n1_done", b_done, cyc >= 5);
            chk1("n1_err", b_err, 1'b0);
            chkw("n1_addr", 32'(b_addr), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hwag_cfg_seq.md
HWAG_CFG_SEQ -- requirements
Module: hwag_cfg_seq

Interface
REQ-001 SHALL have parameter N_REGS, default 71, number of hwag registers to load (1..256).
REQ-002 SHALL have parameter ADDR_W, default 8, ssram address width.
REQ-003 SHALL have parameter DATA_W, default 16, ssram data width.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle load request.
REQ-007 SHALL have port tbl_addr  out  ADDR_W  index into the init table.
REQ-008 SHALL have port tbl_data  in  DATA_W  init value for tbl_addr, combinational.
REQ-009 SHALL have port tbl_vfy  in  1  1 = verify this register on readback.
REQ-010 SHALL have port ssram_we  out  1  hwag register write strobe.
REQ-011 SHALL have port ssram_re  out  1  hwag register read strobe.
REQ-012 SHALL have port ssram_addr  out  ADDR_W  hwag register address.
REQ-013 SHALL have port ssram_wdata  out  DATA_W  write data.
REQ-014 SHALL have port ssram_oe  out  1  drive enable for the external tristate data bus.
REQ-015 SHALL have port ssram_rdata  in  DATA_W  read data, valid one cycle after re.
REQ-016 SHALL have port busy  out  1  sequence in progress.
REQ-017 SHALL have port done  out  1  load and verify passed (sticky).
REQ-018 SHALL have port err  out  1  verify mismatch (sticky).
REQ-019 SHALL have port err_addr  out  ADDR_W  address of first mismatch.

Function
REQ-020 SHALL implement states IDLE, WRITE, TURN, READ, TAIL, DONE, ERR.
REQ-021 SHALL leave IDLE, DONE or ERR for WRITE on start; start in any other state is ignored.
REQ-022 Entering WRITE SHALL clear done, err, err_addr and set the address counter to 0.
REQ-023 WRITE SHALL issue one write per cycle: we=1, oe=1, ssram_addr=tbl_addr=k, wdata=tbl_data, for k=0..N_REGS-1 in order.
REQ-024 TURN SHALL last exactly one cycle, with we=re=oe=0 (bus turnaround).
REQ-025 READ SHALL issue one read per cycle, re=1, ssram_addr=k, k=0..N_REGS-1; expected tbl_data and tbl_vfy SHALL be registered alongside k.
REQ-026 Compare SHALL occur in the cycle after each read (READ cycles 2..N and the single TAIL cycle); mismatch counts only when the registered vfy=1.
REQ-027 On the first counted mismatch at address k SHALL go to ERR: err=1, err_addr=k, re=0 from the next edge, no further reads.
REQ-028 After TAIL with no mismatch SHALL go to DONE, done=1.
REQ-029 Cycle timing: start sampled at edge 0; writes occupy cycles 1..N; TURN at N+1; reads at N+2..2N+1; TAIL at 2N+2; done high from cycle 2N+3.
REQ-030 busy SHALL be 1 in WRITE, TURN, READ and TAIL, 0 otherwise.
REQ-031 we and re SHALL never both be 1; oe SHALL be 1 only in WRITE.
REQ-032 Address counter SHALL be ADDR_W+1 bits wide so that N_REGS=256 terminates without wrap.

Reset
REQ-033 rst low SHALL force IDLE immediately, with all outputs 0 (we, re, oe, busy, done, err, err_addr, ssram_addr, ssram_wdata, tbl_addr).
REQ-034 Reset mid-sequence SHALL abort without completing the current word; no restart after release until start.

Structure
REQ-035 Package hwag_cfg_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and the named hwag register addresses (HWATHNB=4, HWASTWD=5, HWAATOP=6, HWACR0=64, HWATHVL=70).
REQ-036 The init table SHALL be a separate sub-module hwag_cfg_rom driving tbl_data/tbl_vfy from tbl_addr; hwag_cfg_seq SHALL contain no table contents.

Verification
REQ-037 Setup: N_REGS=71, table k->k*3 with vfy=1, echoing ssram model -> 71 writes at addr 0..70, done=1 at cycle 145, err=0.
REQ-038 Setup: model returns 0xFFFF at addr 57 -> err=1, err_addr=57, done=0, re low after the compare, busy=0.
REQ-039 Setup: same corruption at addr 64 but vfy=0 there -> done=1, err=0.
REQ-040 Setup: rst low at the write of addr 20 -> we/re/oe/busy=0 without waiting for a clock edge; after release, idle until start, then a full clean sequence.
REQ-041 Setup: start pulsed during READ -> ignored; start in DONE -> done cleared and writes restart at addr 0.
REQ-042 Setup: N_REGS=1 -> write cycle 1, TURN cycle 2, read cycle 3, TAIL cycle 4, done at cycle 5.
